// File: rtl/sa_feed_ctrl_pkg.sv
// rtl/sa_feed_ctrl_pkg.sv - shared types and constants for the systolic array feed sequencer
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SA_ROWS      = 4;
    localparam int SA_LEN_WIDTH = 8;

    // Step counter must reach len+ROWS-2 for the largest len without wrapping.
    function automatic int t_width(input int len_width, input int rows);
        return len_width + $clog2(rows) + 1;
    endfunction

endpackage

// File: rtl/sa_feed_ctrl_if.sv
// rtl/sa_feed_ctrl_if.sv - command, FIFO and status signals of the feed sequencer
interface sa_feed_ctrl_if
    import sa_pkg::*;
#(
    parameter int ROWS      = SA_ROWS,
    parameter int LEN_WIDTH = SA_LEN_WIDTH
) ();

    logic                 i_start;
    logic [LEN_WIDTH-1:0] i_len;
    logic                 i_abort;
    logic [ROWS-1:0]      i_empty;
    logic [ROWS-1:0]      o_rd;
    logic [ROWS-1:0]      o_valid;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_aborted;
    logic [15:0]          o_stall_cnt;

    modport master (
        output i_start, i_len, i_abort, i_empty,
        input  o_rd, o_valid, o_busy, o_done, o_aborted, o_stall_cnt
    );

    modport slave (
        input  i_start, i_len, i_abort, i_empty,
        output o_rd, o_valid, o_busy, o_done, o_aborted, o_stall_cnt
    );

endinterface

// File: rtl/sa_feed_ctrl_row_window.sv
// rtl/sa_feed_ctrl_row_window.sv - per-row read window compare for the skewed feed
module sa_row_window #(
    parameter int TW        = 11,
    parameter int LEN_WIDTH = 8,
    parameter int ROW       = 0
) (
    input  logic [TW-1:0]        t,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 active
);

    localparam logic [TW-1:0] ROW_T = TW'(ROW);

    logic [TW-1:0] row_end;

    always_comb begin
        row_end = ROW_T + TW'(len);
        active  = (t >= ROW_T) && (t < row_end);
    end

endmodule

// File: rtl/sa_feed_ctrl.sv
// rtl/sa_feed_ctrl.sv - skewed read sequencer for the systolic array row FIFOs
module sa_feed_ctrl
    import sa_pkg::*;
#(
    parameter int ROWS         = SA_ROWS,
    parameter int LEN_WIDTH    = SA_LEN_WIDTH,
    parameter int DRAIN_CYCLES = 2 * ROWS - 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sa_feed_ctrl_if.slave bus
);

    localparam int TW = t_width(LEN_WIDTH, ROWS);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t               state;
    logic [TW-1:0]        t;
    logic [LEN_WIDTH-1:0] len_q;
    logic [DW-1:0]        drain_cnt;
    logic [15:0]          stall_cnt;
    logic                 done_q;
    logic [ROWS-1:0]      active;
    logic                 stall;
    logic                 abort_take;
    logic                 t_last;

    for (genvar r = 0; r < ROWS; r++) begin : g_win
        sa_row_window #(
            .TW       (TW),
            .LEN_WIDTH(LEN_WIDTH),
            .ROW      (r)
        ) u_win (
            .t     (t),
            .len   (len_q),
            .active(active[r])
        );
    end

    // Any active row running dry freezes every row so the diagonal skew stays intact.
    always_comb begin
        stall      = (state == FEED) && |(active & bus.i_empty);
        abort_take = bus.i_abort && ((state == FEED) || (state == DRAIN));
        t_last     = (t == (TW'(len_q) + TW'(ROWS - 2)));
        bus.o_rd   = ((state == FEED) && !stall && !bus.i_abort) ? active : '0;
    end

    assign bus.o_valid     = bus.o_rd;
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_done      = done_q;
    assign bus.o_aborted   = abort_take;
    assign bus.o_stall_cnt = stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            t         <= '0;
            len_q     <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        len_q     <= bus.i_len;
                        t         <= '0;
                        stall_cnt <= '0;
                        if (bus.i_len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (bus.i_abort) begin
                        state <= IDLE;
                    end else if (stall) begin
                        if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
                    end else begin
                        t <= t + 1'b1;
                        if (t_last) begin
                            drain_cnt <= '0;
                            if (DRAIN_CYCLES == 0) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (bus.i_abort) begin
                        state <= IDLE;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
